// File: rtl/reg_write_sequencer.sv
// Byte-stream command decoder: collects A5/ADDR/DHI/DLO/CHK frames and issues
// a single-cycle register-file write, or a one-cycle error pulse on a bad frame.
module reg_write_sequencer #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int addressbits = 16,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   wrEN,
  output logic [addressbits-1:0] address,
  output logic [WIDTH-1:0]       wrData,
  output logic                   err_chk,
  output logic                   err_addr,
  output logic                   err_to,
  output logic                   busy
);

  localparam int         CntW     = $clog2(TIMEOUT + 1);
  localparam logic [7:0] Header   = 8'hA5;
  localparam logic [8:0] DepthLim = (DEPTH > 256) ? 9'd256 : 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DHI, S_DLO, S_CHK, S_WRITE
  } state_e;

  state_e                   state_q;
  logic [CntW-1:0]          idle_q;
  logic [7:0]               addr_q, dhi_q, dlo_q;
  logic                     wr_en_q, err_chk_q, err_addr_q, err_to_q;
  logic [addressbits-1:0]   address_q;
  logic [WIDTH-1:0]         wr_data_q;

  logic                     accept_d;
  logic [7:0]               chk_d;
  logic                     addr_ok_d;

  assign in_ready  = (state_q != S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign accept_d  = in_valid && in_ready;
  assign chk_d     = addr_q ^ dhi_q ^ dlo_q;
  assign addr_ok_d = ({1'b0, addr_q} < DepthLim);

  // NOTE: every state element below is assigned with <= so all flops see the
  // pre-edge values of each other, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idle_q     <= '0;
      addr_q     <= '0;
      dhi_q      <= '0;
      dlo_q      <= '0;
      wr_en_q    <= 1'b0;
      err_chk_q  <= 1'b0;
      err_addr_q <= 1'b0;
      err_to_q   <= 1'b0;
      address_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_en_q    <= 1'b0;
      err_chk_q  <= 1'b0;
      err_addr_q <= 1'b0;
      err_to_q   <= 1'b0;

      if (state_q == S_WRITE) begin
        state_q <= S_IDLE;
        idle_q  <= '0;
      end else if (accept_d) begin
        idle_q <= '0;
        unique case (state_q)
          S_IDLE: if (in_data == Header) state_q <= S_ADDR;
          S_ADDR: begin addr_q <= in_data; state_q <= S_DHI; end
          S_DHI:  begin dhi_q  <= in_data; state_q <= S_DLO; end
          S_DLO:  begin dlo_q  <= in_data; state_q <= S_CHK; end
          S_CHK: begin
            // Checksum failure outranks an out-of-range address.
            if (in_data != chk_d) begin
              err_chk_q <= 1'b1;
              state_q   <= S_IDLE;
            end else if (!addr_ok_d) begin
              err_addr_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              wr_en_q   <= 1'b1;
              address_q <= addressbits'(addr_q);
              wr_data_q <= WIDTH'({dhi_q, dlo_q});
              state_q   <= S_WRITE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        // A byte on the expiring cycle wins, so the timeout only fires here.
        if (idle_q == CntW'(TIMEOUT - 1)) begin
          err_to_q <= 1'b1;
          idle_q   <= '0;
          state_q  <= S_IDLE;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end else begin
        idle_q <= '0;
      end
    end
  end

  assign wrEN     = wr_en_q;
  assign err_chk  = err_chk_q;
  assign err_addr = err_addr_q;
  assign err_to   = err_to_q;
  assign address  = address_q;
  assign wrData   = wr_data_q;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Bench for reg_write_sequencer: directed frames followed by randomized frames,
// all outputs compared each cycle against a frame-buffer reference model.
module tb_reg_write_sequencer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wrEN;
  logic [15:0] address;
  logic [15:0] wrData;
  logic        err_chk;
  logic        err_addr;
  logic        err_to;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  reg_write_sequencer #(
    .WIDTH(16), .DEPTH(DEPTH), .addressbits(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wrEN(wrEN), .address(address), .wrData(wrData),
    .err_chk(err_chk), .err_addr(err_addr), .err_to(err_to), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the frame collected so far, idle count, and
  // the expected registered outputs.
  logic [7:0]  m_q[$];
  int          m_idle;
  bit          m_wcycle;
  bit          m_wr, m_chk, m_addr, m_to;
  logic [15:0] m_address, m_wrdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit acc, input logic [7:0] d);
    logic [7:0] c;
    m_wr = 0; m_chk = 0; m_addr = 0; m_to = 0;
    if (r) begin
      m_q.delete(); m_idle = 0; m_wcycle = 0;
      m_address = 16'h0; m_wrdata = 16'h0;
    end else if (m_wcycle) begin
      m_wcycle = 0;
    end else if (acc) begin
      m_idle = 0;
      if (m_q.size() != 0 || d == 8'hA5) m_q.push_back(d);
      if (m_q.size() == 5) begin
        c = m_q[1] ^ m_q[2] ^ m_q[3];
        if (m_q[4] != c) m_chk = 1;
        else if (int'(m_q[1]) >= DEPTH) m_addr = 1;
        else begin
          m_wr = 1; m_wcycle = 1;
          m_address = {8'h00, m_q[1]};
          m_wrdata  = {m_q[2], m_q[3]};
        end
        m_q.delete();
      end
    end else if (m_q.size() != 0) begin
      if (m_idle == TIMEOUT - 1) begin
        m_to = 1; m_idle = 0; m_q.delete();
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d, output bit acc);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d;
    check("in_ready", 32'(in_ready), 32'(!m_wcycle));
    check("busy",     32'(busy),     32'(m_q.size() != 0 || m_wcycle));
    check("wrEN",     32'(wrEN),     32'(m_wr));
    check("err_chk",  32'(err_chk),  32'(m_chk));
    check("err_addr", 32'(err_addr), 32'(m_addr));
    check("err_to",   32'(err_to),   32'(m_to));
    check("address",  32'(address),  32'(m_address));
    check("wrData",   32'(wrData),   32'(m_wrdata));
    check("one_hot_pulse", 32'(int'(wrEN) + int'(err_chk) + int'(err_addr) + int'(err_to) <= 1), 32'(1));
    acc = !r && v && !m_wcycle;
    @(posedge clk);
    model_edge(r, acc, d);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 8'($urandom), a);
  endtask

  // Holds in_valid until the byte is taken; bounded so a stuck in_ready ends.
  task automatic send(input logic [7:0] b);
    bit a;
    a = 0;
    for (int t = 0; t < 4 && !a; t++) step(0, 1, b, a);
    if (!a) check("send_accept_bound", 32'(0), 32'(1));
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [7:0] c);
    send(8'hA5); send(a); send(hi); send(lo); send(c);
  endtask

  initial begin
    bit          a;
    logic [7:0]  fr[5];
    int          kind, gap;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clk);
    model_edge(1, 0, 8'h00);
    step(1, 1, 8'hA5, a);
    #1;
    check("reset_busy",    32'(busy),     32'(0));
    check("reset_ready",   32'(in_ready), 32'(1));
    check("reset_address", 32'(address),  32'(0));

    // Good write, then in_ready low only in the write cycle.
    send_frame(8'h03, 8'h12, 8'h34, 8'h25);
    #1;
    check("dir_wr_en",    32'(wrEN),     32'(1));
    check("dir_wr_addr",  32'(address),  32'h0003);
    check("dir_wr_data",  32'(wrData),   32'h1234);
    check("dir_wr_ready", 32'(in_ready), 32'(0));
    idle(1);
    #1;
    check("dir_wr_single", 32'(wrEN), 32'(0));

    // Checksum error leaves the last write untouched.
    send_frame(8'h03, 8'h12, 8'h34, 8'h26);
    #1;
    check("dir_chk_pulse", 32'(err_chk), 32'(1));
    check("dir_chk_data",  32'(wrData),  32'h1234);
    idle(1);

    // Address out of range.
    send_frame(8'h08, 8'h00, 8'h01, 8'h09);
    #1;
    check("dir_addr_pulse", 32'(err_addr), 32'(1));
    check("dir_addr_nowr",  32'(wrEN),     32'(0));
    idle(1);

    // Mid-frame timeout, then a normal frame.
    send(8'hA5); send(8'h03);
    idle(TIMEOUT);
    #1;
    check("dir_to_pulse", 32'(err_to), 32'(1));
    check("dir_to_busy",  32'(busy),   32'(0));
    send_frame(8'h02, 8'h55, 8'hAA, 8'h02 ^ 8'h55 ^ 8'hAA);
    idle(1);

    // Leading junk dropped, streamed frame written.
    send(8'h00); send(8'hFF);
    send_frame(8'h05, 8'hAB, 8'hCD, 8'h63);
    #1;
    check("dir_stream_addr", 32'(address), 32'h0005);
    check("dir_stream_data", 32'(wrData),  32'hABCD);
    // Back-to-back frame: its header waits through the write cycle.
    send_frame(8'h01, 8'hA5, 8'h00, 8'h01 ^ 8'hA5);
    idle(1);

    // Reset mid-frame, overriding a byte presented with it.
    send(8'hA5); send(8'h03); send(8'h12);
    step(1, 1, 8'h34, a);
    send_frame(8'h01, 8'h00, 8'h02, 8'h03);
    #1;
    check("dir_rst_addr", 32'(address), 32'h0001);
    check("dir_rst_data", 32'(wrData),  32'h0002);

    // Randomized frames: good, corrupted, junk-prefixed, stalled, reset.
    for (int f = 0; f < 200; f++) begin
      kind  = $urandom_range(0, 9);
      fr[0] = 8'hA5;
      fr[1] = 8'($urandom_range(0, 11));
      fr[2] = 8'($urandom);
      fr[3] = 8'($urandom);
      fr[4] = fr[1] ^ fr[2] ^ fr[3];
      if (kind == 0) fr[4] = fr[4] ^ (8'h01 << $urandom_range(0, 7));
      if (kind == 1) for (int j = 0; j < 3; j++) send(8'($urandom));
      for (int j = 0; j < 5; j++) begin
        gap = $urandom_range(0, 2);
        if (kind == 2 && j == 3) gap = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
        if (kind == 3 && j == 3) step(1, 1, fr[j], a);
        idle(gap);
        send(fr[j]);
      end
    end
    idle(TIMEOUT + 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
